uart_tx: RTL and testbench

Serial UART transmitter, 8N1 by default, for the GPS/USB UART path. Accepts bytes over a single-cycle valid/ready handshake into a one-entry holding register and shifts them out LSB-first on `tx` at a rate set by a baud-period counter. It is the transmit partner of the design's UART receiver and uses the same `baud_cnt_max` bit-period parameter, so both ends share one baud setting. The holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, data width, default baud period and frame lengths.
package uart_pkg;

    localparam int          UART_DATA_BITS         = 8;
    localparam logic [15:0] UART_BAUD_DEFAULT      = 16'd5207;
    localparam int          UART_FRAME_BITS        = 10;
    localparam int          UART_FRAME_BITS_PARITY = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle between a byte producer and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] ip_data;
    logic                      ip_flag;
    logic                      ready;
    logic                      busy;
    logic                      tx;

    modport master (output ip_data, ip_flag, input ready, busy, tx);
    modport slave  (input ip_data, ip_flag, output ready, busy, tx);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..baud_cnt_max while enabled, held at zero otherwise,
// and pulses bit_end_o on the last cycle of each bit. Shared with the UART receiver.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter logic [15:0] baud_cnt_max = UART_BAUD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic bit_end_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!en_i || cnt_q == baud_cnt_max) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = en_i && (cnt_q == baud_cnt_max);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default, with a one-entry holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by parity_odd).
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [15:0] baud_cnt_max = UART_BAUD_DEFAULT
`ifdef UART_TX_PARITY_EN
    ,
    parameter logic        parity_odd   = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    uart_tx_if.slave bus
);

    logic [2:0]                state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bitCnt_q, bitCnt_d;
    logic [UART_DATA_BITS-1:0] holdData_q, holdData_d;
    logic                      holdValid_q, holdValid_d;
    logic                      tx_q, tx_d;
    logic                      load;
    logic                      bitEnd;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    uart_baud_gen #(
        .baud_cnt_max(baud_cnt_max)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q != IDLE),
        .bit_end_o(bitEnd)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitCnt_d    = bitCnt_q;
        holdData_d  = holdData_q;
        holdValid_d = holdValid_q;
        tx_d        = tx_q;
        load        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        if (bus.ip_flag && !holdValid_q) begin
            holdData_d  = bus.ip_data;
            holdValid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                load = holdValid_q;
            end
            START: begin
                if (bitEnd) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitCnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d  = shift_q >> 1;
                        bitCnt_d = bitCnt_q + 3'd1;
                        tx_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    if (holdValid_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Draining the holding register also restarts the frame; the baud counter is already at zero here.
        if (load) begin
            state_d     = START;
            tx_d        = 1'b0;
            shift_d     = holdData_q;
            bitCnt_d    = 3'd0;
            holdValid_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d    = (^holdData_q) ^ parity_odd;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitCnt_q    <= 3'd0;
            holdData_q  <= '0;
            holdValid_q <= 1'b0;
            tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            holdData_q  <= holdData_d;
            holdValid_q <= holdValid_d;
            tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.ready = !holdValid_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: scoreboard-checked random traffic on a fast-baud instance,
// plus directed frames on a default-baud instance and an odd-parity instance.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam logic [15:0] BAUD_A = 16'd15;
    localparam int          BIT_A  = 16;
    localparam int          BIT_B  = int'(UART_BAUD_DEFAULT) + 1;
`ifdef UART_TX_PARITY_EN
    localparam bit          PARITY_ON = 1'b1;
`else
    localparam bit          PARITY_ON = 1'b0;
`endif
    localparam int FRAME_LEN = PARITY_ON ? UART_FRAME_BITS_PARITY : UART_FRAME_BITS;
    localparam logic ODD_A = 1'b0;
    localparam logic ODD_B = 1'b0;
    localparam logic ODD_C = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if ifA();
    uart_tx_if ifB();
    uart_tx_if ifC();

    uart_tx #(
        .baud_cnt_max(BAUD_A)
`ifdef UART_TX_PARITY_EN
        , .parity_odd(ODD_A)
`endif
    ) dutA (.clk(clk), .rst(rst), .bus(ifA));

    uart_tx #(
        .baud_cnt_max(UART_BAUD_DEFAULT)
`ifdef UART_TX_PARITY_EN
        , .parity_odd(ODD_B)
`endif
    ) dutB (.clk(clk), .rst(rst), .bus(ifB));

    uart_tx #(
        .baud_cnt_max(BAUD_A)
`ifdef UART_TX_PARITY_EN
        , .parity_odd(ODD_C)
`endif
    ) dutC (.clk(clk), .rst(rst), .bus(ifC));

    int vecCount  = 0;
    int missCount = 0;
    int cycle     = 0;

    logic [7:0] expQ[$];
    int         startQ[$];

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference frame, bit 0 first on the line: start, data LSB-first, optional parity, stop.
    function automatic logic [10:0] frameBits(input logic [7:0] data, input logic odd);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = data[i];
        if (PARITY_ON) f[9] = (($countones(data) % 2) == 1) ^ odd;
        return f;
    endfunction

    function automatic logic readyOf(input int d);
        case (d)
            0:       return ifA.ready;
            1:       return ifB.ready;
            default: return ifC.ready;
        endcase
    endfunction

    function automatic logic txOf(input int d);
        case (d)
            0:       return ifA.tx;
            1:       return ifB.tx;
            default: return ifC.tx;
        endcase
    endfunction

    function automatic logic busyOf(input int d);
        case (d)
            0:       return ifA.busy;
            1:       return ifB.busy;
            default: return ifC.busy;
        endcase
    endfunction

    task automatic drive(input int d, input logic [7:0] data, input logic flag);
        case (d)
            0:       begin ifA.ip_data = data; ifA.ip_flag = flag; end
            1:       begin ifB.ip_data = data; ifB.ip_flag = flag; end
            default: begin ifC.ip_data = data; ifC.ip_flag = flag; end
        endcase
    endtask

    // Offer one byte once ready is high; returns 1ns after the accepting edge.
    task automatic applyStimulus(input int d, input logic [7:0] data, input int maxWait);
        int n;
        n = 0;
        @(negedge clk);
        while (!readyOf(d) && n < maxWait) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyWait", 32'(readyOf(d)), 32'd1);
        if (!readyOf(d)) return;
        drive(d, data, 1'b1);
        @(posedge clk);
        if (d == 0) expQ.push_back(data);
        #1 drive(d, 8'h00, 1'b0);
    endtask

    // Scoreboard monitor for DUT A: a falling line from idle pops the next expected byte.
    logic        monActive = 1'b0;
    logic        monSkip   = 1'b0;
    logic [10:0] monBits;
    int          monIdx, monCyc, monWrong;

    always @(negedge clk) begin
        if (rst) begin
            monActive = 1'b0;
        end else begin
            if (!monActive && ifA.tx === 1'b0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFrame", 32'd1, 32'd0);
                    monSkip = 1'b1;
                    monBits = frameBits(8'h00, ODD_A);
                end else begin
                    monSkip = 1'b0;
                    monBits = frameBits(expQ.pop_front(), ODD_A);
                end
                monActive = 1'b1;
                monIdx    = 0;
                monCyc    = 0;
                monWrong  = 0;
                startQ.push_back(cycle);
            end
            if (monActive) begin
                if (ifA.tx !== monBits[monIdx]) monWrong++;
                if (monCyc == BIT_A - 1) begin
                    if (!monSkip)
                        checkOutput($sformatf("aBit%0d wrongCycles", monIdx), 32'(monWrong), 32'd0);
                    monWrong = 0;
                    monCyc   = 0;
                    monIdx++;
                    if (monIdx == FRAME_LEN) monActive = 1'b0;
                end else begin
                    monCyc++;
                end
            end
        end
    end

    task automatic waitIdle(input int maxCycles);
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
            done = !ifA.busy && ifA.ready && (expQ.size() == 0) && !monActive;
        end
        checkOutput("idleReached", 32'(done), 32'd1);
    endtask

    // Directed frame check on DUT d: every line bit must hold its value for exactly bitLen cycles.
    task automatic directFrame(input int d, input logic [7:0] data, input logic odd,
                               input int bitLen, input string tag);
        logic [10:0] f;
        int          n, wrong;
        f = frameBits(data, odd);
        applyStimulus(d, data, 10);
        n = 0;
        @(negedge clk);
        while (txOf(d) !== 1'b0 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "StartSeen"}, 32'(txOf(d)), 32'd0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            wrong = 0;
            for (int c = 0; c < bitLen; c++) begin
                if (txOf(d) !== f[i]) wrong++;
                @(negedge clk);
            end
            checkOutput($sformatf("%sBit%0d wrongCycles", tag, i), 32'(wrong), 32'd0);
        end
        checkOutput({tag, "BusyDone"}, 32'(busyOf(d)), 32'd0);
        checkOutput({tag, "TxIdle"}, 32'(txOf(d)), 32'd1);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int a, b;
        logic r;

        rst = 1'b1;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstTx", 32'(ifA.tx), 32'd1);
        checkOutput("rstReady", 32'(ifA.ready), 32'd1);
        checkOutput("rstBusy", 32'(ifA.busy), 32'd0);
        checkOutput("rstTxB", 32'(ifB.tx), 32'd1);
        rst = 1'b0;

        $display("[TB] single byte A5 and handshake latency");
        applyStimulus(0, 8'hA5, 10);
        checkOutput("aReadyAfterAccept", 32'(ifA.ready), 32'd0);
        checkOutput("aBusyBeforeStart", 32'(ifA.busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("aTxFalls", 32'(ifA.tx), 32'd0);
        checkOutput("aBusyRises", 32'(ifA.busy), 32'd1);
        checkOutput("aReadyAfterLoad", 32'(ifA.ready), 32'd1);
        n = 1;
        while (n < 1000) begin
            @(posedge clk);
            #1;
            if (!ifA.busy) break;
            n++;
        end
        checkOutput("aBusyCycles", 32'(n), 32'(FRAME_LEN * BIT_A));
        waitIdle(100);

        $display("[TB] back-to-back 00 then FF");
        startQ.delete();
        applyStimulus(0, 8'h00, 10);
        applyStimulus(0, 8'hFF, 4 * BIT_A);
        n = 0;
        while (ifA.ready == 1'b0 && n < 20 * BIT_A) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("aReadyLowCycles", 32'(n), 32'(FRAME_LEN * BIT_A - 1));
        waitIdle(40 * BIT_A);
        checkOutput("aFramesSeen", 32'(startQ.size()), 32'd2);
        if (startQ.size() >= 2)
            checkOutput("aFrameSpacing", 32'(startQ[1] - startQ[0]), 32'(FRAME_LEN * BIT_A));

        $display("[TB] ip_flag held high with changing data");
        for (int k = 0; k < 3 * FRAME_LEN * BIT_A + 7; k++) begin
            @(negedge clk);
            r = ifA.ready;
            drive(0, 8'($urandom), 1'b1);
            @(posedge clk);
            if (r) expQ.push_back(ifA.ip_data);
        end
        #1 drive(0, 8'h00, 1'b0);
        waitIdle(60 * BIT_A);

        $display("[TB] random bytes with random gaps");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 8'($urandom), 30 * BIT_A);
            repeat ($urandom_range(0, 2 * FRAME_LEN * BIT_A)) @(posedge clk);
        end
        applyStimulus(0, 8'h07, 30 * BIT_A);
        waitIdle(60 * BIT_A);

        $display("[TB] reset during data bit 3 of 3C with a byte held");
        applyStimulus(0, 8'h3C, 10);
        applyStimulus(0, 8'h81, 4 * BIT_A);
        repeat (4 * BIT_A + 3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstTx", 32'(ifA.tx), 32'd1);
        checkOutput("midRstReady", 32'(ifA.ready), 32'd1);
        checkOutput("midRstBusy", 32'(ifA.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        a = 0;
        b = 0;
        for (int k = 0; k < 2 * FRAME_LEN * BIT_A; k++) begin
            @(negedge clk);
            if (ifA.tx !== 1'b1) a++;
            if (ifA.busy !== 1'b0) b++;
        end
        checkOutput("postRstTxLowCycles", 32'(a), 32'd0);
        checkOutput("postRstBusyCycles", 32'(b), 32'd0);

        $display("[TB] parity sense on odd-parity instance");
        directFrame(2, 8'h07, ODD_C, BIT_A, "c07");
        directFrame(2, 8'hA5, ODD_C, BIT_A, "cA5");

        $display("[TB] default baud period, byte 55");
        directFrame(1, 8'h55, ODD_B, BIT_B, "b55");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
